// File: rtl/seq_det.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : seq_det
// Purpose  : Moore FSM that flags the serial bit pattern 1-0-1 (oldest first).
//            Define SEQ_DET_OVERLAP_EN for overlapping detection; team builds
//            normally define it.
// Revision : 1.0 - initial release
// ============================================================================
module seq_det (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S0;
        case (state_q)
            S0: state_d = in ? S1 : S0;
            S1: state_d = in ? S1 : S2;
            S2: state_d = in ? S3 : S0;
            S3: begin
`ifdef SEQ_DET_OVERLAP_EN
                // The trailing "1" of a match starts the next "10" prefix.
                state_d = in ? S1 : S2;
`else
                state_d = in ? S1 : S0;
`endif
            end
            default: state_d = S0;
        endcase
    end

    assign out = (state_q == S3);

endmodule
`default_nettype wire

// File: tb/tb_seq_det.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_det
// Purpose  : Table-driven self-checking bench for seq_det.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det;

    logic clk;
    logic rst;
    logic din;
    logic dout;

    int checks;
    int errors;

    seq_det dut (
        .clk (clk),
        .rst (rst),
        .in  (din),
        .out (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  r;
        logic  b;
        logic  e;
        string tag;
    } vec_t;

    vec_t vecs[$];

`ifdef SEQ_DET_OVERLAP_EN
    localparam logic OVL = 1'b1;
`else
    localparam logic OVL = 1'b0;
`endif

    task automatic add(input logic r, input logic b, input logic e, input string tag);
        vec_t v;
        v.r = r; v.b = b; v.e = e; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic r, input logic b, input logic e, input string tag);
        @(negedge clk);
        rst = r;
        din = b;
        @(posedge clk);
        #1;
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL %s: out=%0b expected %0b", tag, dout, e);
        end
    endtask

    // out may never be high on two consecutive cycles
    logic prev_out;
    logic mon_en;
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (prev_out === 1'b1 && dout === 1'b1) begin
                errors++;
                $display("FAIL double_pulse: out=%0b expected 0", dout);
            end
        end
        prev_out = dout;
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        din      = 1'b0;
        mon_en   = 1'b0;
        prev_out = 1'b0;

        // reset held with in toggling
        add(1, 0, 0, "rst0");
        add(1, 1, 0, "rst1");
        // basic detect 0,1,0,1
        add(0, 0, 0, "basic1");
        add(0, 1, 0, "basic2");
        add(0, 0, 0, "basic3");
        add(0, 1, 1, "basic4");
        add(1, 0, 0, "rst_a");
        // stream 0,1,0,1,1,0,1,0,1,0
        add(0, 0, 0,   "strm1");
        add(0, 1, 0,   "strm2");
        add(0, 0, 0,   "strm3");
        add(0, 1, 1,   "strm4");
        add(0, 1, 0,   "strm5");
        add(0, 0, 0,   "strm6");
        add(0, 1, 1,   "strm7");
        add(0, 0, 0,   "strm8");
        add(0, 1, OVL, "strm9");
        add(0, 0, 0,   "strm10");
        add(1, 0, 0, "rst_b");
        // reset mid-pattern
        add(0, 1, 0, "mid1");
        add(0, 0, 0, "mid2");
        add(1, 1, 0, "mid_rst");
        add(0, 1, 0, "mid3");
        add(0, 0, 0, "mid4");
        add(0, 1, 1, "mid5");
        add(1, 0, 0, "rst_c");
        for (int i = 0; i < 10; i++) add(0, 1, 0, "ones");
        for (int i = 0; i < 10; i++) add(0, 0, 0, "zeros");
        // 1,1,0,1
        add(0, 1, 0, "p1101_1");
        add(0, 1, 0, "p1101_2");
        add(0, 0, 0, "p1101_3");
        add(0, 1, 1, "p1101_4");
        add(0, 0, 0, "p1101_5");

        // first two edges are reset edges: check state register too
        apply(vecs[0].r, vecs[0].b, vecs[0].e, vecs[0].tag);
        mon_en = 1'b1;
        apply(vecs[1].r, vecs[1].b, vecs[1].e, vecs[1].tag);
        checks++;
        if (dut.state_q !== 2'b00) begin
            errors++;
            $display("FAIL rst_state: state=%0b expected 00", dut.state_q);
        end
        for (int i = 2; i < vecs.size(); i++) begin
            apply(vecs[i].r, vecs[i].b, vecs[i].e, vecs[i].tag);
        end

        // rst held through a full 1,0,1 must suppress detection
        apply(1, 1, 0, "hold1");
        apply(1, 0, 0, "hold2");
        apply(1, 1, 0, "hold3");
        checks++;
        if (dut.state_q !== 2'b00) begin
            errors++;
            $display("FAIL hold_state: state=%0b expected 00", dut.state_q);
        end

        // a rst pulse between edges must be ignored
        apply(0, 1, 0, "glitch1");
        apply(0, 0, 0, "glitch2");
        @(negedge clk);
        din = 1'b1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (dout !== 1'b1) begin
            errors++;
            $display("FAIL rst_glitch: out=%0b expected 1", dout);
        end
        // 10101 tail: second detect only with overlap
        apply(0, 0, 0, "ovl_a");
        apply(0, 1, OVL, "ovl_b");
        apply(0, 1, 0, "ovl_c");

        @(negedge clk);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
